pipeline_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. It collects stall requests from the ID, EX and MEM stages, detects load-use hazards, and drives a per-stage stall vector to the PC register and the four inter-stage buffers (if_id, id_ex, ex_mem, mem_wb). It sequences exception/branch-redirect flushes and supplies the redirect PC. It also tracks stall duration for a watchdog and a performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: control levels,
// register-address bus width, stall vector masks and controller state encoding.
package pipeline_ctrl_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int REGS_ADDR_BUS = 5;
    localparam int STALL_W       = 6;

    // Bit order: PC, if_id, id_ex, ex_mem, mem_wb, wb
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID-stage source that depends on
// a load still in EX. Zero latency, no state; shareable with forwarding logic.
module hazard_detect #(
    parameter int ADDR_W = 5
) (
    input  logic              ex_mem_read_i,
    input  logic              ex_write_enable_i,
    input  logic [ADDR_W-1:0] ex_write_addr_i,
    input  logic              id_read_enable_1_i,
    input  logic [ADDR_W-1:0] id_read_addr_1_i,
    input  logic              id_read_enable_2_i,
    input  logic [ADDR_W-1:0] id_read_addr_2_i,
    output logic              load_use_o
);

    logic ex_load_dest;
    logic src1_hit;
    logic src2_hit;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign ex_load_dest = ex_mem_read_i & ex_write_enable_i & (ex_write_addr_i != '0);
    assign src1_hit     = id_read_enable_1_i & (id_read_addr_1_i == ex_write_addr_i);
    assign src2_hit     = id_read_enable_2_i & (id_read_addr_2_i == ex_write_addr_i);
    assign load_use_o   = ex_load_dest & (src1_hit | src2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: zero-latency stall vector, registered flush/redirect
// sequencing, sticky stall watchdog and saturating stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int WATCHDOG_LIMIT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall_req_id,
    input  logic                      stall_req_ex,
    input  logic                      stall_req_mem,
    input  logic                      ex_mem_read,
    input  logic                      ex_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
    input  logic                      id_read_enable_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_1,
    input  logic                      id_read_enable_2,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_2,
    input  logic                      flush_req,
    input  logic [PC_WIDTH-1:0]       flush_pc,
    input  logic                      perf_clear,
    output logic [STALL_W-1:0]        stall,
    output logic                      flush,
    output logic [PC_WIDTH-1:0]       new_pc,
    output logic                      busy,
    output logic                      stall_timeout,
    output logic [31:0]               stall_cycles
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WD_LIMIT   = 8'(WATCHDOG_LIMIT);

    state_e              state_q;
    logic                flush_q;
    logic [PC_WIDTH-1:0] new_pc_q;
    logic                busy_q;
    logic [3:0]          flush_cnt_q;
    logic [7:0]          run_cnt_q, run_cnt_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    logic                load_use;
    logic [STALL_W-1:0]  stall_req_vec;
    logic                stalling;

    hazard_detect #(
        .ADDR_W (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .ex_mem_read_i      (ex_mem_read),
        .ex_write_enable_i  (ex_write_enable),
        .ex_write_addr_i    (ex_write_addr),
        .id_read_enable_1_i (id_read_enable_1),
        .id_read_addr_1_i   (id_read_addr_1),
        .id_read_enable_2_i (id_read_enable_2),
        .id_read_addr_2_i   (id_read_addr_2),
        .load_use_o         (load_use)
    );

    // Deepest requester wins; a stage's hold implies holding everything upstream of it.
    always_comb begin
        stall_req_vec = STALL_NONE;
        if (stall_req_mem) begin
            stall_req_vec = STALL_MEM;
        end else if (stall_req_ex) begin
            stall_req_vec = STALL_EX;
        end else if (stall_req_id || load_use) begin
            stall_req_vec = STALL_ID;
        end
    end

    assign stall    = (reset || (state_q == FLUSH)) ? STALL_NONE : stall_req_vec;
    assign stalling = (stall != STALL_NONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            flush_q     <= DISABLE;
            new_pc_q    <= '0;
            busy_q      <= DISABLE;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                FLUSH: begin
                    // A new redirect while flushing wins and restarts the full flush window.
                    if (flush_req) begin
                        new_pc_q    <= flush_pc;
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= RUN;
                        flush_q <= DISABLE;
                        busy_q  <= DISABLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                default: begin
                    if (flush_req) begin
                        state_q     <= FLUSH;
                        flush_q     <= ENABLE;
                        busy_q      <= ENABLE;
                        new_pc_q    <= flush_pc;
                        flush_cnt_q <= '0;
                    end else if (stalling) begin
                        state_q <= STALL;
                        busy_q  <= ENABLE;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= DISABLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        run_cnt_d = '0;
        if (stalling) begin
            run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (run_cnt_d == WD_LIMIT);

        stall_cycles_d = stall_cycles_q;
        if (perf_clear) begin
            stall_cycles_d = '0;
        end else if (stalling && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_cnt_q      <= '0;
            timeout_q      <= DISABLE;
            stall_cycles_q <= '0;
        end else begin
            run_cnt_q      <= run_cnt_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign busy          = busy_q;
    assign stall_timeout = timeout_q;
    assign stall_cycles  = stall_cycles_q;

endmodule
